tpx3_cmd_rx: RTL

//  Chip-side receiver for the serial command link that tpx3_core drives toward the Timepix3 (DataIn, EnableIn).

---
 rtl/tpx3_cmd_pkg.sv | 24 ++
 rtl/tpx3_cmd_rx_if.sv | 19 +
 rtl/tpx3_cmd_rx_fifo.sv | 44 ++++
 rtl/tpx3_cmd_rx.sv | 136 +++++++++++++
 4 files changed

// File: rtl/tpx3_cmd_pkg.sv
// Shared definitions for the tpx3 serial command link: receiver state encoding,
// FIFO entry layout and the default sync byte shared with the transmitter.
package tpx3_cmd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHunt,
        StPayload
    } rx_state_e;

    localparam int unsigned EntryW   = 10;
    localparam int unsigned ByteLsb  = 0;
    localparam int unsigned EofBit   = 8;
    localparam int unsigned SofBit   = 9;

    localparam logic [7:0] DefaultSyncByte = 8'hAA;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/tpx3_cmd_rx_if.sv
// Byte stream from the command receiver: head entry with frame marks and a
// valid/ready handshake.
interface tpx3_cmd_rx_if;
    logic [7:0] DATA_OUT;
    logic       DATA_SOF;
    logic       DATA_EOF;
    logic       DATA_VALID;
    logic       DATA_READY;

    modport master (
        output DATA_OUT, DATA_SOF, DATA_EOF, DATA_VALID,
        input  DATA_READY
    );

    modport slave (
        input  DATA_OUT, DATA_SOF, DATA_EOF, DATA_VALID,
        output DATA_READY
    );
endinterface

// File: rtl/tpx3_cmd_rx_fifo.sv
// Single-clock first-word-fall-through FIFO; a write while full succeeds when a
// read frees the head slot on the same edge.
module tpx3_cmd_rx_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_wr = wr && (!full || rd);
    assign do_rd = rd && !empty;
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + (AW+1)'(1);
            if (do_rd) rptr <= rptr + (AW+1)'(1);
        end
    end

    // Storage is left unreset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/tpx3_cmd_rx.sv
// Chip-side command link receiver: hunts for the sync byte, frames the payload
// into bytes with SOF/EOF marks and keeps frame and error counters.
module tpx3_cmd_rx
    import tpx3_cmd_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE  = DefaultSyncByte,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 CLK40,
    input  logic                 RST,
    input  logic                 EnableIn,
    input  logic                 DataIn,
    tpx3_cmd_rx_if.master        dout,
    output logic [CNT_WIDTH-1:0] FRAME_CNT,
    output logic [7:0]           ERR_CNT,
    output logic                 OVERFLOW
);
    rx_state_e         state;
    logic [7:0]        shreg;
    logic [2:0]        bitcnt;
    logic [7:0]        hold;
    logic              hold_valid;
    logic              hold_sof;
    logic              sof_pending;

    logic [7:0]        shifted;
    logic              push;
    logic              push_eof;
    logic              partial;
    logic              hunt_err;
    logic              pop;
    logic              drop;
    logic [1:0]        err_inc;
    logic [EntryW-1:0] head;
    logic              full;
    logic              empty;

    assign shifted = {shreg[6:0], DataIn};

    always_comb begin
        push     = 1'b0;
        push_eof = 1'b0;
        partial  = 1'b0;
        if (state == StPayload) begin
            if (!EnableIn) begin
                push     = hold_valid;
                push_eof = 1'b1;
                partial  = (bitcnt != 3'd0);
            end else if (bitcnt == 3'd7) begin
                push = hold_valid;
            end
        end
        hunt_err = (state == StHunt) && !EnableIn;
        pop      = !empty && dout.DATA_READY;
        drop     = push && full && !pop;
        err_inc  = {1'b0, partial} + {1'b0, drop} + {1'b0, hunt_err};
    end

    always_ff @(posedge CLK40) begin
        if (RST) begin
            state       <= StIdle;
            shreg       <= '0;
            bitcnt      <= '0;
            hold        <= '0;
            hold_valid  <= 1'b0;
            hold_sof    <= 1'b0;
            sof_pending <= 1'b0;
            FRAME_CNT   <= '0;
            ERR_CNT     <= '0;
            OVERFLOW    <= 1'b0;
        end else begin
            ERR_CNT <= sat_add8(ERR_CNT, err_inc);
            if (drop) OVERFLOW <= 1'b1;
            unique case (state)
                StIdle: begin
                    // Clear history so a new frame cannot match on stale bits.
                    if (EnableIn) begin
                        state <= StHunt;
                        shreg <= {7'b0, DataIn};
                    end
                end
                StHunt: begin
                    if (!EnableIn) begin
                        state <= StIdle;
                    end else begin
                        shreg <= shifted;
                        if (shifted == SYNC_BYTE) begin
                            state       <= StPayload;
                            bitcnt      <= '0;
                            sof_pending <= 1'b1;
                        end
                    end
                end
                StPayload: begin
                    if (!EnableIn) begin
                        state       <= StIdle;
                        FRAME_CNT   <= FRAME_CNT + CNT_WIDTH'(1);
                        hold_valid  <= 1'b0;
                        sof_pending <= 1'b0;
                        bitcnt      <= '0;
                    end else begin
                        shreg  <= shifted;
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            hold        <= shifted;
                            hold_valid  <= 1'b1;
                            hold_sof    <= sof_pending;
                            sof_pending <= 1'b0;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    tpx3_cmd_rx_fifo #(
        .WIDTH (EntryW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK40),
        .rst   (RST),
        .wr    (push),
        .wdata ({hold_sof, push_eof, hold}),
        .rd    (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign dout.DATA_VALID = !empty;
    assign dout.DATA_OUT   = empty ? 8'h00 : head[ByteLsb +: 8];
    assign dout.DATA_SOF   = !empty && head[SofBit];
    assign dout.DATA_EOF   = !empty && head[EofBit];
endmodule
